// File: rtl/piso_serializer.sv
// piso_serializer: accepts a WIDTH-bit word over valid/ready and sends it one bit per CLK, with first/last strobes and optional even parity.
// Latency: the first serial bit is on SOUT in the cycle after the accept edge; consecutive frames run with no idle gap.
// Backpressure: IN_READY is high only in IDLE or on the last-bit cycle; a held IN_VALID waits, and IN is sampled only on accept.
module piso_serializer #(
  parameter int WIDTH     = 4,
  parameter int MSB_FIRST = 0,
  parameter int PARITY_EN = 0
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [WIDTH-1:0] IN,
  input  logic             IN_VALID,
  output logic             IN_READY,
  output logic             SOUT,
  output logic             SOUT_VALID,
  output logic             SOUT_FIRST,
  output logic             SOUT_LAST,
  output logic             BUSY
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, SHIFT, PAR} state_t;

  state_t           state, state_d;
  logic [WIDTH-1:0] shreg, shreg_d;
  logic [WIDTH-1:0] in_ord;
  logic [CW-1:0]    cnt, cnt_d, nxt;
  logic             sout_d, sout_vld_d, sout_first_d, sout_last_d;
  logic             accept;

  // Ready depends only on registered state, never on IN_VALID.
  assign IN_READY = (state == IDLE) | (SOUT_LAST & SOUT_VALID);
  assign accept   = IN_VALID & IN_READY;
  assign BUSY     = SOUT_VALID;

  // Reorder IN into transmit order so captured bit k is always frame bit k.
  always_comb begin
    in_ord = '0;
    for (int i = 0; i < WIDTH; i++) begin
      in_ord[i] = (MSB_FIRST != 0) ? IN[WIDTH-1-i] : IN[i];
    end
  end

  // Next-state and next-output logic; cnt is the index of the bit now on SOUT.
  always_comb begin
    state_d      = state;
    shreg_d      = shreg;
    cnt_d        = cnt;
    sout_d       = 1'b0;
    sout_vld_d   = 1'b0;
    sout_first_d = 1'b0;
    sout_last_d  = 1'b0;
    nxt          = cnt + CW'(1);
    if (accept) begin
      // Bit 0 is registered straight from the incoming word: one-cycle latency.
      state_d      = SHIFT;
      shreg_d      = in_ord;
      cnt_d        = '0;
      sout_d       = in_ord[0];
      sout_vld_d   = 1'b1;
      sout_first_d = 1'b1;
    end else begin
      case (state)
        SHIFT: begin
          if (cnt == CW'(WIDTH-1)) begin
            if (PARITY_EN != 0) begin
              // Even parity: XOR of the captured word (bit order is irrelevant).
              state_d     = PAR;
              sout_d      = ^shreg;
              sout_vld_d  = 1'b1;
              sout_last_d = 1'b1;
            end else begin
              state_d = IDLE;
            end
          end else begin
            cnt_d       = nxt;
            sout_d      = shreg[nxt];
            sout_vld_d  = 1'b1;
            sout_last_d = (PARITY_EN == 0) && (nxt == CW'(WIDTH-1));
          end
        end
        PAR:     state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // State, captured word, counter and all serial outputs are flops; reset aborts any frame.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state      <= IDLE;
      shreg      <= '0;
      cnt        <= '0;
      SOUT       <= 1'b0;
      SOUT_VALID <= 1'b0;
      SOUT_FIRST <= 1'b0;
      SOUT_LAST  <= 1'b0;
    end else begin
      state      <= state_d;
      shreg      <= shreg_d;
      cnt        <= cnt_d;
      SOUT       <= sout_d;
      SOUT_VALID <= sout_vld_d;
      SOUT_FIRST <= sout_first_d;
      SOUT_LAST  <= sout_last_d;
    end
  end

endmodule
